// File: rtl/rot_arbiter_pkg.sv
// Shared widths, direction encoding and the direction-to-right-amount helper
// used by the rotating arbiter.
package rot_arbiter_pkg;
    localparam int DATA_W = 4;
    localparam int AMT_W  = 2;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Left by n is the same as right by (4-n) mod 4; two's complement in AMT_W bits does the wrap.
    function automatic logic [AMT_W-1:0] right_amt(input logic dir, input logic [AMT_W-1:0] amt);
        return (dir == DIR_LEFT) ? ((~amt) + AMT_W'(1)) : amt;
    endfunction
endpackage

// File: rtl/rot_arbiter_rot4.sv
// Purely combinational 4-bit rotate-right: out[k] = in[(k+amt) mod 4].
module rot4
    import rot_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] in,
    input  logic [AMT_W-1:0]  amt,
    output logic [DATA_W-1:0] out
);
    always_comb begin
        out = in;
        unique case (amt)
            2'd0: out = in;
            2'd1: out = {in[0], in[3:1]};
            2'd2: out = {in[1:0], in[3:2]};
            2'd3: out = {in[2:0], in[3]};
            default: out = in;
        endcase
    end
endmodule

// File: rtl/rot_arbiter.sv
// Round-robin arbiter feeding one shared nibble rotator into a single-entry output slot.
// Optional per-requester saturating grant counters are built when ROT_ARBITER_STATS_EN is defined.
module rot_arbiter
    import rot_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [DATA_W*NREQ-1:0]     req_data,
    input  logic [AMT_W*NREQ-1:0]      req_amt,
    input  logic [NREQ-1:0]            req_dir,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NREQ)-1:0]    out_src
`ifdef ROT_ARBITER_STATS_EN
    ,
    output logic [CNT_W*NREQ-1:0]      grant_cnt
`endif
);
    localparam int SRC_W = $clog2(NREQ);

    logic              slot_free;
    logic              any_grant;
    logic [NREQ-1:0]   grant;
    logic [SRC_W-1:0]  win;
    logic [SRC_W-1:0]  nxt_ptr;
    logic [SRC_W-1:0]  rr_ptr;
    logic [DATA_W-1:0] sel_data;
    logic [AMT_W-1:0]  sel_amt;
    logic              sel_dir;
    logic [DATA_W-1:0] rot_out;
    int                scan;

    assign slot_free = !out_valid || out_ready;

    // Scan from rr_ptr upward, wrapping at NREQ; first valid requester wins.
    always_comb begin
        any_grant = 1'b0;
        win       = '0;
        scan      = 0;
        if (!rst && slot_free) begin
            for (int i = 0; i < NREQ; i++) begin
                scan = int'(rr_ptr) + i;
                if (scan >= NREQ) scan = scan - NREQ;
                if (!any_grant && req_valid[SRC_W'(scan)]) begin
                    any_grant = 1'b1;
                    win       = SRC_W'(scan);
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (any_grant) grant[win] = 1'b1;
    end

    assign req_ready = grant;
    assign nxt_ptr   = (win == SRC_W'(NREQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        sel_data = '0;
        sel_amt  = '0;
        sel_dir  = DIR_RIGHT;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                sel_data = req_data[k*DATA_W +: DATA_W];
                sel_amt  = req_amt[k*AMT_W +: AMT_W];
                sel_dir  = req_dir[k];
            end
        end
    end

    rot4 u_rot4 (
        .in  (sel_data),
        .amt (right_amt(sel_dir, sel_amt)),
        .out (rot_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (any_grant) begin
            out_valid <= 1'b1;
            out_data  <= rot_out;
            out_src   <= win;
            rr_ptr    <= nxt_ptr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ROT_ARBITER_STATS_EN
    logic [CNT_W-1:0] cnt [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst)
                cnt[g] <= '0;
            else if (grant[g] && (cnt[g] != '1))
                cnt[g] <= cnt[g] + 1'b1;
        end
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end
`endif
endmodule
